sensor_request_dispatcher: RTL and testbench

- Parametrised successor to the PC-to-sensor glue. It sits between the UART receive path (2-byte request) and the UART transmit path (2-byte response).
- Decodes each request, routes it to one of NUM_SENSORS sensor channels over a start/done handshake, and queues responses in a FIFO toward the transmitter.
- Adds a continuous-monitoring mode: periodic automatic re-polling of one channel until cancelled.

---
 rtl/sensor_request_dispatcher.sv | 225 ++++++++++++++++++++++
 tb/tb_sensor_request_dispatcher.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_request_dispatcher.sv
// Decodes 2-byte UART requests, polls one of NUM_SENSORS channels, and queues responses for transmit.
// Optional macro SENSOR_TIMEOUT_EN adds a WAIT-state timeout that answers 0x1F/0xEE.
module sensor_request_dispatcher #(
    parameter int NUM_SENSORS    = 32,
    parameter int FIFO_DEPTH     = 4,
    parameter int MONITOR_PERIOD = 50_000_000,
    parameter int TIMEOUT_CYCLES = 5_000_000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req_valid,
    input  logic [7:0]               req_command,
    input  logic [7:0]               req_address,
    input  logic                     cancel_monitoring,
    output logic                     busy,
    output logic [NUM_SENSORS-1:0]   sensor_start,
    output logic [7:0]               sensor_command,
    input  logic [NUM_SENSORS-1:0]   sensor_done,
    input  logic [NUM_SENSORS-1:0]   sensor_error,
    input  logic [8*NUM_SENSORS-1:0] sensor_data,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [7:0]               rsp_command,
    output logic [7:0]               rsp_value,
    output logic                     monitoring
);
    localparam int SW = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = $clog2(MONITOR_PERIOD + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, PUSH, MON_WAIT} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   addr_q, addr_d;
    logic [7:0]      op_q, op_d;
    logic            mon_d;
    logic            pstop_q, pstop_d;
    logic [7:0]      pcmd_q, pcmd_d, pval_q, pval_d;
    logic [PW-1:0]   period_cnt;
    logic            stop_evt, sel_done, timed_out, push, pop, full;
    logic [7:0]      sel_data;

    logic [7:0]      mem_cmd [FIFO_DEPTH];
    logic [7:0]      mem_val [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;

    assign stop_evt = (req_valid && req_command == 8'h06) || cancel_monitoring;
    assign sel_done = sensor_done[addr_q];
    assign sel_data = sensor_data[8*addr_q +: 8];
    assign busy     = (state_q != IDLE);
    assign full     = (count == (AW+1)'(FIFO_DEPTH));
    assign pop      = rsp_valid && rsp_ready;
    assign push     = (state_q == PUSH) && (!full || pop);

`ifdef SENSOR_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] timeout_cnt;

    always_ff @(posedge clock) begin
        if (reset)
            timeout_cnt <= '0;
        else if (state_q == ISSUE)
            timeout_cnt <= TW'(1);
        else if (state_q == WAIT && timeout_cnt != TW'(TIMEOUT_CYCLES))
            timeout_cnt <= timeout_cnt + TW'(1);
    end

    assign timed_out = (state_q == WAIT) && (timeout_cnt == TW'(TIMEOUT_CYCLES));
`else
    assign timed_out = 1'b0;
`endif

    always_comb begin
        sensor_start         = '0;
        sensor_command       = 8'h00;
        if (state_q == ISSUE) begin
            sensor_start[addr_q] = 1'b1;
            sensor_command       = op_q;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        op_d    = op_q;
        mon_d   = monitoring;
        pstop_d = pstop_q;
        pcmd_d  = pcmd_q;
        pval_d  = pval_q;
        case (state_q)
            IDLE: begin
                pstop_d = 1'b0;
                // A simultaneous cancel swallows the request.
                if (req_valid && !cancel_monitoring) begin
                    if (32'(req_address) >= NUM_SENSORS) begin
                        pcmd_d  = 8'hFF;
                        pval_d  = req_address;
                        state_d = PUSH;
                    end else begin
                        addr_d = req_address[SW-1:0];
                        case (req_command)
                            8'h01, 8'h02, 8'h03: begin
                                op_d    = req_command;
                                state_d = ISSUE;
                            end
                            8'h04, 8'h05: begin
                                op_d    = req_command - 8'h02;
                                mon_d   = 1'b1;
                                state_d = ISSUE;
                            end
                            default: begin
                                pcmd_d  = 8'hFF;
                                pval_d  = req_command;
                                state_d = PUSH;
                            end
                        endcase
                    end
                end
            end
            ISSUE: begin
                if (monitoring && stop_evt) pstop_d = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (sel_done || timed_out) begin
                    state_d = PUSH;
                    if (pstop_q || (monitoring && stop_evt)) begin
                        pcmd_d  = 8'h0A;
                        pval_d  = 8'h00;
                        mon_d   = 1'b0;
                        pstop_d = 1'b0;
                    end else if (!sel_done) begin
                        pcmd_d = 8'h1F;
                        pval_d = 8'hEE;
                    end else if (sensor_error[addr_q]) begin
                        pcmd_d = 8'h1F;
                        pval_d = sel_data;
                    end else begin
                        case (op_q)
                            8'h02:   begin pcmd_d = 8'h09; pval_d = sel_data; end
                            8'h03:   begin pcmd_d = 8'h08; pval_d = sel_data; end
                            default: begin pcmd_d = 8'h07; pval_d = 8'h00;    end
                        endcase
                    end
                end else if (monitoring && stop_evt) begin
                    pstop_d = 1'b1;
                end
            end
            PUSH: begin
                if (monitoring && stop_evt) pstop_d = 1'b1;
                if (!full || pop) state_d = monitoring ? MON_WAIT : IDLE;
            end
            MON_WAIT: begin
                if (stop_evt || pstop_q) begin
                    mon_d   = 1'b0;
                    pstop_d = 1'b0;
                    pcmd_d  = 8'h0A;
                    pval_d  = 8'h00;
                    state_d = PUSH;
                end else if (period_cnt >= PW'(MONITOR_PERIOD - 1)) begin
                    state_d = ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            op_q       <= 8'h00;
            monitoring <= 1'b0;
            pstop_q    <= 1'b0;
            pcmd_q     <= 8'h00;
            pval_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            op_q       <= op_d;
            monitoring <= mon_d;
            pstop_q    <= pstop_d;
            pcmd_q     <= pcmd_d;
            pval_q     <= pval_d;
        end
    end

    // Period counts cycles since the last ISSUE and saturates at the reload point.
    always_ff @(posedge clock) begin
        if (reset)
            period_cnt <= '0;
        else if (state_q == ISSUE)
            period_cnt <= PW'(1);
        else if (period_cnt < PW'(MONITOR_PERIOD - 1))
            period_cnt <= period_cnt + PW'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_cmd[i] <= 8'h00;
                mem_val[i] <= 8'h00;
            end
        end else begin
            if (push) begin
                mem_cmd[wr_ptr] <= pcmd_q;
                mem_val[wr_ptr] <= pval_q;
                wr_ptr          <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                count <= count + (AW+1)'(1);
            else if (pop && !push)
                count <= count - (AW+1)'(1);
        end
    end

    assign rsp_valid   = (count != '0);
    assign rsp_command = mem_cmd[rd_ptr];
    assign rsp_value   = mem_val[rd_ptr];
endmodule

// File: tb/tb_sensor_request_dispatcher.sv
// Directed self-checking bench for sensor_request_dispatcher (4 channels, 2-entry FIFO, period 100).
// Define SENSOR_TIMEOUT_EN on both files to exercise the timeout path.
module tb_sensor_request_dispatcher;
    localparam int NS = 4;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            req_valid = 1'b0;
    logic [7:0]      req_command = 8'h00;
    logic [7:0]      req_address = 8'h00;
    logic            cancel_monitoring = 1'b0;
    logic            busy;
    logic [NS-1:0]   sensor_start;
    logic [7:0]      sensor_command;
    logic [NS-1:0]   sensor_done = '0;
    logic [NS-1:0]   sensor_error = '0;
    logic [8*NS-1:0] sensor_data = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [7:0]      rsp_command;
    logic [7:0]      rsp_value;
    logic            monitoring;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    sensor_request_dispatcher #(
        .NUM_SENSORS(NS), .FIFO_DEPTH(2), .MONITOR_PERIOD(100), .TIMEOUT_CYCLES(50)
    ) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_command(req_command),
        .req_address(req_address), .cancel_monitoring(cancel_monitoring), .busy(busy),
        .sensor_start(sensor_start), .sensor_command(sensor_command), .sensor_done(sensor_done),
        .sensor_error(sensor_error), .sensor_data(sensor_data), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_command(rsp_command), .rsp_value(rsp_value),
        .monitoring(monitoring)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] cmd, input logic [7:0] addr);
        req_command = cmd;
        req_address = addr;
        req_valid   = 1'b1;
        tick();
        req_valid   = 1'b0;
    endtask

    task automatic pulseDone(input int ch, input logic err, input logic [7:0] data);
        sensor_done[ch]        = 1'b1;
        sensor_error[ch]       = err;
        sensor_data[8*ch +: 8] = data;
        tick();
        sensor_done  = '0;
        sensor_error = '0;
    endtask

    task automatic popEntry(input string tag, input logic [7:0] cmd, input logic [7:0] val);
        checkOutput({tag, "_valid"}, rsp_valid, 1);
        checkOutput({tag, "_cmd"}, rsp_command, cmd);
        checkOutput({tag, "_val"}, rsp_value, val);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic waitStart(input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            if (sensor_start != '0) begin
                at = cyc;
                break;
            end
            tick();
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_rsp_valid"}, rsp_valid, 0);
        checkOutput({tag, "_start"}, sensor_start, 0);
        checkOutput({tag, "_scmd"}, sensor_command, 0);
        checkOutput({tag, "_mon"}, monitoring, 0);
        checkOutput({tag, "_rsp_cmd"}, rsp_command, 0);
        checkOutput({tag, "_rsp_val"}, rsp_value, 0);
    endtask

    initial begin
        int t0, t1, starts;

        repeat (3) tick();
        checkAllZero("reset");
        reset = 1'b0;
        tick();

        // Single temperature read on channel 0 and its 2-cycle response latency.
        applyStimulus(8'h02, 8'h00);
        checkOutput("temp_start", sensor_start, 4'b0001);
        checkOutput("temp_scmd", sensor_command, 8'h02);
        checkOutput("temp_busy", busy, 1);
        tick();
        checkOutput("temp_start_one_cycle", sensor_start, 0);
        repeat (2) tick();
        pulseDone(0, 1'b0, 8'h19);
        checkOutput("temp_lat1", rsp_valid, 0);
        tick();
        popEntry("temp", 8'h09, 8'h19);
        checkOutput("temp_idle", busy, 0);

        // Invalid address / command responses, including the boundary address and stray stop.
        applyStimulus(8'h03, 8'h07);
        checkOutput("badaddr_nostart", sensor_start, 0);
        tick();
        popEntry("badaddr", 8'hFF, 8'h07);
        applyStimulus(8'h55, 8'h01);
        tick();
        popEntry("badcmd", 8'hFF, 8'h55);
        applyStimulus(8'h02, 8'h04);
        tick();
        popEntry("addr_eq_n", 8'hFF, 8'h04);
        applyStimulus(8'h06, 8'h01);
        tick();
        popEntry("stop_idle", 8'hFF, 8'h06);

        // Continuous humidity on channel 2, cancelled during the third WAIT.
        rsp_ready = 1'b1;
        applyStimulus(8'h05, 8'h02);
        checkOutput("mon_start", sensor_start, 4'b0100);
        checkOutput("mon_scmd", sensor_command, 8'h03);
        checkOutput("mon_flag", monitoring, 1);
        t0 = cyc;
        repeat (3) tick();
        pulseDone(2, 1'b0, 8'h2A);
        tick();
        checkOutput("mon1_valid", rsp_valid, 1);
        checkOutput("mon1_cmd", rsp_command, 8'h08);
        checkOutput("mon1_val", rsp_value, 8'h2A);
        tick();
        checkOutput("mon1_popped", rsp_valid, 0);
        checkOutput("mon_wait_busy", busy, 1);
        waitStart(200, t1);
        checkOutput("mon_period", t1 - t0, 100);
        checkOutput("mon2_start", sensor_start, 4'b0100);
        t0 = t1;
        repeat (2) tick();
        pulseDone(2, 1'b0, 8'h2A);
        tick();
        checkOutput("mon2_cmd", rsp_command, 8'h08);
        checkOutput("mon2_val", rsp_value, 8'h2A);
        waitStart(200, t1);
        checkOutput("mon_period2", t1 - t0, 100);
        tick();
        cancel_monitoring = 1'b1;
        tick();
        cancel_monitoring = 1'b0;
        tick();
        pulseDone(2, 1'b0, 8'h2A);
        checkOutput("cancel_mon_cleared", monitoring, 0);
        tick();
        checkOutput("cancel_valid", rsp_valid, 1);
        checkOutput("cancel_cmd", rsp_command, 8'h0A);
        checkOutput("cancel_val", rsp_value, 8'h00);
        tick();
        checkOutput("cancel_idle", busy, 0);
        checkOutput("cancel_empty", rsp_valid, 0);
        starts = 0;
        for (int i = 0; i < 150; i++) begin
            if (sensor_start != '0) starts++;
            tick();
        end
        checkOutput("no_repoll", starts, 0);

        // Continuous temperature stopped by a 0x06 request while in MON_WAIT.
        applyStimulus(8'h04, 8'h00);
        tick();
        pulseDone(0, 1'b0, 8'h11);
        tick();
        checkOutput("stopreq_first_cmd", rsp_command, 8'h09);
        checkOutput("stopreq_first_val", rsp_value, 8'h11);
        tick();
        applyStimulus(8'h06, 8'h03);
        checkOutput("stopreq_mon", monitoring, 0);
        tick();
        checkOutput("stopreq_cmd", rsp_command, 8'h0A);
        checkOutput("stopreq_valid", rsp_valid, 1);
        tick();
        rsp_ready = 1'b0;
        checkOutput("stopreq_idle", busy, 0);

        // Backpressure: two entries fill the FIFO, the third stalls in PUSH.
        applyStimulus(8'h01, 8'h01);
        checkOutput("status_start", sensor_start, 4'b0010);
        checkOutput("status_scmd", sensor_command, 8'h01);
        tick();
        pulseDone(1, 1'b0, 8'h55);
        tick();
        applyStimulus(8'h01, 8'h01);
        tick();
        pulseDone(1, 1'b0, 8'h66);
        tick();
        applyStimulus(8'h01, 8'h01);
        tick();
        pulseDone(1, 1'b1, 8'h33);
        tick();
        checkOutput("stall_busy", busy, 1);
        checkOutput("stall_head", rsp_command, 8'h07);
        applyStimulus(8'h02, 8'h00);
        tick();
        checkOutput("drop_nostart", sensor_start, 0);
        checkOutput("stall_busy2", busy, 1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checkOutput("stall_release", busy, 0);
        popEntry("order2", 8'h07, 8'h00);
        popEntry("order3", 8'h1F, 8'h33);
        checkOutput("order_empty", rsp_valid, 0);
        checkOutput("drop_no_txn", busy, 0);

        // Reset in WAIT abandons the transaction; a late done is ignored.
        applyStimulus(8'h02, 8'h03);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pulseDone(3, 1'b0, 8'h77);
        repeat (2) tick();
        checkAllZero("midreset");

`ifdef SENSOR_TIMEOUT_EN
        applyStimulus(8'h02, 8'h03);
        for (int i = 0; i < 80; i++) begin
            if (rsp_valid) break;
            tick();
        end
        checkOutput("timeout_valid", rsp_valid, 1);
        checkOutput("timeout_cmd", rsp_command, 8'h1F);
        checkOutput("timeout_val", rsp_value, 8'hEE);
        checkOutput("timeout_idle", busy, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
